mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Sequences all memory traffic for the TSC CPU over a single shared bus: readM/writeM, address, bidirectional data, and the inputReady completion strobe.
- Arbitrates between two requesters: the datapath's instruction-fetch port and its data (load/store) port.
- Runs one handshake at a time, captures read data, and returns a one-cycle ack to the winning requester.
- Counts completed instruction fetches for the debug num_inst path.

Parameters:
- WORD_SIZE, 16, width of address and data words.
- TIMEOUT_CYCLES, 15, bus-wait limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request, level.
- if_addr  input  WORD_SIZE  fetch address (PC).
- if_ack  output  1  one-cycle pulse when the fetch completes.
- if_data  output  WORD_SIZE  last fetched instruction word.
- d_req  input  1  data request, level.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  WORD_SIZE  data address.
- d_wdata  input  WORD_SIZE  store data.
- d_ack  output  1  one-cycle pulse when the data access completes.
- d_rdata  output  WORD_SIZE  last loaded word.
- readM  output  1  memory read strobe.
- writeM  output  1  memory write strobe.
- address  output  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  shared memory data bus.
- inputReady  input  1  memory completion strobe.
- num_fetch  output  WORD_SIZE  completed fetch count.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  timeout error pulse.

Behaviour:
- Clocking and reset:
  - Single clock, clk; reset_n is asynchronous, active-low.
  - Reset forces state IDLE and clears every output to 0: readM, writeM, address, if_ack, d_ack, if_data, d_rdata, num_fetch, busy, err.
  - data is high-Z during reset.
  - Reset mid-transfer drops the strobe immediately, issues no ack, and loses the transfer. Requesters must re-request.
- FSM states: IDLE, RD, WR, ACK. All outputs are registered.
- IDLE:
  - Samples requests. d_req has priority over if_req.
  - On grant, latch the address (plus d_we and d_wdata for a data grant) and record the owner (I or D).
  - Next state is WR for a data store, otherwise RD.
  - inputReady is ignored in IDLE.
- RD:
  - readM=1; address holds the latched value.
  - On a rising edge with inputReady=1, capture data into the owner's register (if_data or d_rdata), clear readM, and go to ACK.
- WR:
  - writeM=1; data is driven with the latched wdata.
  - On inputReady=1, clear writeM, release data to Z, and go to ACK.
- ACK:
  - The owner's ack is 1 for exactly this cycle; then go to IDLE.
  - On a fetch ack, num_fetch increments by 1, wrapping from 2^WORD_SIZE-1 to 0.
- Latency:
  - Request seen at edge 0 → strobe high in cycle 1.
  - inputReady sampled high at edge k → ack high in cycle k+1.
  - Minimum latency is 3 cycles from request to ack.
- Requester rule:
  - Requester must drop req on the edge at which it samples ack=1. IDLE then sees req=0, so no duplicate access occurs.
  - A req still high in IDLE is treated as a new access.
- Simultaneous if_req and d_req: the data access is served first, and the fetch is granted in the following IDLE cycle.
- Data bus: driven only in WR; high-Z in all other states.
- readM and writeM are never both high.
- if_data and d_rdata hold their values until the next completed read by the same owner.
- address holds its last value in IDLE and ACK.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to RD or WR and increments each cycle without inputReady.
  - When it reaches TIMEOUT_CYCLES, the strobe drops and the FSM goes to ACK.
  - err=1 is pulsed together with the owner's ack. The rdata register is unchanged, and num_fetch still increments for a fetch.
  - inputReady arriving on the same edge as the timeout wins: normal completion, err=0.
- When undefined: no counter is built, the FSM waits indefinitely, and err is tied to 0.

Test Plan:
- Basic fetch: reset, then if_req with if_addr=0x0010; memory returns 0x6000 with inputReady 2 cycles after readM rises → readM high 1 cycle after grant, address=0x0010, if_ack single pulse 1 cycle after inputReady, if_data=0x6000, num_fetch=1, busy low afterwards.
- Arbitration: if_req(0x0011) and d_req load(0x0080) raised in the same cycle, memory returns 0x1234 then 0x6001 → load served first, d_rdata=0x1234; then fetch, if_data=0x6001; num_fetch increments once.
- Store: d_req, d_we=1, d_addr=0x0040, d_wdata=0xBEEF → writeM=1, readM=0, data bus=0xBEEF until inputReady; data high-Z in the ack cycle; d_ack single pulse.
- Reset mid-read: reset_n low while readM=1 → readM=0, busy=0, data high-Z without waiting for a clock edge; no ack; after release, state is IDLE.
- Spurious/timeout case 1: inputReady pulsed in IDLE → no ack, no state change.
- Spurious/timeout case 2 (MEM_TIMEOUT_EN): read with no inputReady → readM drops after 15 cycles, if_ack and err pulse together.
- Spurious/timeout case 2 (macro undefined): readM stays high for 100 cycles and err stays 0.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - shared memory bus sequencer for the TSC CPU fetch and data ports
//
// Arbitrates between the instruction-fetch port and the load/store port and runs one
// readM/writeM handshake at a time on the shared bus.
// Optional build macro: MEM_TIMEOUT_EN enables the bus-wait timeout and the err pulse.
//
// Ports:
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   if_req, if_addr               fetch request level and PC
//   if_ack, if_data               fetch completion pulse and last fetched word
//   d_req, d_we, d_addr, d_wdata  data request level, store select, address, store data
//   d_ack, d_rdata                data completion pulse and last loaded word
//   readM, writeM, address, data  memory strobes, address and bidirectional data bus
//   inputReady                    memory completion strobe
//   num_fetch                     completed fetch count (wraps)
//   busy                          high whenever the FSM is not IDLE
//   err                           timeout pulse, coincident with the owner's ack
module mem_access_sequencer #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_ack,
  output logic [WORD_SIZE-1:0] if_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] num_fetch,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t               state;
  logic                 owner_d;   // 1: current access belongs to the data port
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 drive_en;  // registered so reset releases the bus immediately

  assign data = drive_en ? wdata_q : {WORD_SIZE{1'bz}};

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Count reaches this value on the last waiting cycle; the strobe is high for
  // exactly TIMEOUT_CYCLES cycles before the FSM gives up.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
`else
  // No timeout hardware in this build; the comparison folds to a constant 0.
  assign err = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      wdata_q   <= '0;
      drive_en  <= 1'b0;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      address   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_data   <= '0;
      d_rdata   <= '0;
      num_fetch <= '0;
      busy      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err       <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Data port wins; a still-pending fetch is granted in the next IDLE cycle.
          if (d_req) begin
            owner_d <= 1'b1;
            address <= d_addr;
            wdata_q <= d_wdata;
            busy    <= 1'b1;
            if (d_we) begin
              state    <= WR;
              writeM   <= 1'b1;
              drive_en <= 1'b1;
            end else begin
              state <= RD;
              readM <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else if (if_req) begin
            owner_d <= 1'b0;
            address <= if_addr;
            busy    <= 1'b1;
            state   <= RD;
            readM   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        RD, WR: begin
          // inputReady is checked first so it beats a timeout on the same edge.
          if (inputReady) begin
            if (state == RD) begin
              if (owner_d) d_rdata <= data;
              else         if_data <= data;
            end
            readM    <= 1'b0;
            writeM   <= 1'b0;
            drive_en <= 1'b0;
            state    <= ACK;
            if (owner_d) d_ack <= 1'b1;
            else begin
              if_ack    <= 1'b1;
              num_fetch <= num_fetch + 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            readM    <= 1'b0;
            writeM   <= 1'b0;
            drive_en <= 1'b0;
            state    <= ACK;
            err      <= 1'b1;
            if (owner_d) d_ack <= 1'b1;
            else begin
              if_ack    <= 1'b1;
              num_fetch <= num_fetch + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - randomized transaction-level bench for mem_access_sequencer
module tb_mem_access_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_ack;
  logic [W-1:0] if_data;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic         d_ack;
  logic [W-1:0] d_rdata;
  logic         readM;
  logic         writeM;
  logic [W-1:0] address;
  wire  [W-1:0] data;
  logic         inputReady = 1'b0;
  logic [W-1:0] num_fetch;
  logic         busy;
  logic         err;

  logic [W-1:0] mem_drive = '0;
  logic         mem_en = 1'b0;
  assign data = mem_en ? mem_drive : {W{1'bz}};

  always #5 clk = ~clk;

  mem_access_sequencer #(.WORD_SIZE(W), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .num_fetch(num_fetch), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: memory contents plus what each requester last received.
  logic [W-1:0] mem_model [logic [W-1:0]];
  logic [W-1:0] exp_if_data = '0;
  logic [W-1:0] exp_d_rdata = '0;
  logic [W-1:0] exp_fetches = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_get(input logic [W-1:0] a);
    if (!mem_model.exists(a)) mem_model[a] = W'($urandom);
    return mem_model[a];
  endfunction

  // Drive a probe onto the bus; it reads back intact only if the DUT is not driving.
  task automatic probe_bus(input string tag);
    logic [W-1:0] p;
    p = W'($urandom) | 16'h0101;
    mem_en = 1'b1; mem_drive = p;
    #1;
    check(tag, 32'(data), 32'(p));
    mem_en = 1'b0;
  endtask

  // Serve one granted access, starting at a negedge with the strobe still low.
  task automatic serve(input bit is_d, input bit we, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata, input int delay, input int exp_lat);
    int lat;
    bit store;
    logic [W-1:0] val;
    store = is_d && we;
    lat = 0;
    while (!(readM || writeM) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("strobe_latency", 32'(lat), 32'(exp_lat));
    check("address", 32'(address), 32'(addr));
    check("readM", 32'(readM), 32'(!store));
    check("writeM", 32'(writeM), 32'(store));
    check("busy_active", 32'(busy), 32'd1);
    if (store) begin
      check("store_bus", 32'(data), 32'(wdata));
      mem_model[addr] = wdata;
      val = wdata;
    end else begin
      val = mem_get(addr);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("strobe_hold", 32'(readM || writeM), 32'd1);
      check("no_early_ack", 32'(if_ack || d_ack), 32'd0);
      check("err_hold", 32'(err), 32'd0);
    end
    inputReady = 1'b1;
    if (!store) begin
      mem_en = 1'b1; mem_drive = val;
    end
    @(negedge clk);
    inputReady = 1'b0;
    mem_en = 1'b0;
    if (!store) begin
      if (is_d) exp_d_rdata = val;
      else      exp_if_data = val;
    end
    if (!is_d) exp_fetches = exp_fetches + 1'b1;
    check("if_ack", 32'(if_ack), 32'(!is_d));
    check("d_ack", 32'(d_ack), 32'(is_d));
    check("strobe_off", 32'(readM || writeM), 32'd0);
    check("err_normal", 32'(err), 32'd0);
    check("if_data", 32'(if_data), 32'(exp_if_data));
    check("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
    check("num_fetch", 32'(num_fetch), 32'(exp_fetches));
    if (store) probe_bus("bus_released_ack");
    if (is_d) d_req = 1'b0;
    else      if_req = 1'b0;
    @(negedge clk);
    check("ack_single", 32'(if_ack || d_ack), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic req_fetch(input logic [W-1:0] a);
    if_req = 1'b1; if_addr = a;
  endtask

  task automatic req_data(input bit we, input logic [W-1:0] a, input logic [W-1:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    int cnt;
    logic [W-1:0] a1, a2, wd;
    int kind, dly;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_readM", 32'(readM), 32'd0);
    check("rst_writeM", 32'(writeM), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_acks", 32'(if_ack || d_ack), 32'd0);
    check("rst_if_data", 32'(if_data), 32'd0);
    check("rst_d_rdata", 32'(d_rdata), 32'd0);
    check("rst_num_fetch", 32'(num_fetch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    probe_bus("rst_bus_z");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic fetch
    mem_model[16'h0010] = 16'h6000;
    req_fetch(16'h0010);
    serve(1'b0, 1'b0, 16'h0010, '0, 2, 1);

    // Simultaneous requests: load first, then fetch
    mem_model[16'h0080] = 16'h1234;
    mem_model[16'h0011] = 16'h6001;
    req_fetch(16'h0011);
    req_data(1'b0, 16'h0080, '0);
    serve(1'b1, 1'b0, 16'h0080, '0, 1, 1);
    serve(1'b0, 1'b0, 16'h0011, '0, 0, 1);

    // Store, then load it back
    req_data(1'b1, 16'h0040, 16'hBEEF);
    serve(1'b1, 1'b1, 16'h0040, 16'hBEEF, 2, 1);
    req_data(1'b0, 16'h0040, '0);
    serve(1'b1, 1'b0, 16'h0040, '0, 0, 1);

    // Spurious inputReady in IDLE
    inputReady = 1'b1;
    @(negedge clk);
    inputReady = 1'b0;
    check("spur_strobe", 32'(readM || writeM), 32'd0);
    check("spur_ack", 32'(if_ack || d_ack), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("spur_ack2", 32'(if_ack || d_ack), 32'd0);

    // inputReady on the last waiting cycle completes normally
    req_fetch(16'h0020);
    serve(1'b0, 1'b0, 16'h0020, '0, 14, 1);

`ifdef MEM_TIMEOUT_EN
    // Read with no completion: 15 strobe cycles, then ack + err
    req_fetch(16'h0030);
    @(negedge clk);
    cnt = 0;
    while (readM && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    exp_fetches = exp_fetches + 1'b1;
    check("to_strobe_cycles", 32'(cnt), 32'd15);
    check("to_if_ack", 32'(if_ack), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_if_data", 32'(if_data), 32'(exp_if_data));
    check("to_num_fetch", 32'(num_fetch), 32'(exp_fetches));
    if_req = 1'b0;
    @(negedge clk);
    check("to_err_pulse", 32'(err), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
`else
    // No timeout hardware: the strobe waits 100 cycles with err low
    req_fetch(16'h0030);
    serve(1'b0, 1'b0, 16'h0030, '0, 100, 1);
`endif

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      a1 = W'($urandom_range(0, 7));
      a2 = W'($urandom_range(0, 7)) + 16'h0100;
      wd = W'($urandom);
      dly = int'($urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) begin
        inputReady = 1'b1;
        @(negedge clk);
        inputReady = 1'b0;
        check("rnd_spur_ack", 32'(if_ack || d_ack), 32'd0);
      end
      case (kind)
        0: begin
          req_fetch(a2);
          serve(1'b0, 1'b0, a2, '0, dly, 1);
        end
        1: begin
          req_data(1'b0, a1, '0);
          serve(1'b1, 1'b0, a1, '0, dly, 1);
        end
        2: begin
          req_data(1'b1, a1, wd);
          serve(1'b1, 1'b1, a1, wd, dly, 1);
        end
        default: begin
          req_fetch(a2);
          req_data(wd[0], a1, wd);
          serve(1'b1, wd[0], a1, wd, dly, 1);
          serve(1'b0, 1'b0, a2, '0, int'($urandom_range(0, 3)), 1);
        end
      endcase
    end

    // Reset in the middle of a read
    req_fetch(16'h0050);
    @(negedge clk);
    check("mid_readM_before", 32'(readM), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_readM", 32'(readM), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ack", 32'(if_ack), 32'd0);
    check("mid_num_fetch", 32'(num_fetch), 32'd0);
    check("mid_if_data", 32'(if_data), 32'd0);
    probe_bus("mid_bus_z");
    if_req = 1'b0;
    exp_fetches = '0;
    exp_if_data = '0;
    exp_d_rdata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_strobe", 32'(readM || writeM), 32'd0);
    check("post_rst_ack", 32'(if_ack || d_ack), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Fresh fetch after reset counts from zero
    req_fetch(16'h0060);
    serve(1'b0, 1'b0, 16'h0060, '0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
